// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_AW           = 32;
  localparam int unsigned DEF_DW           = 32;
  localparam int unsigned DEF_MAX_OUT      = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Which requester an outstanding memory transaction belongs to.
  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } tag_e;

  // Holding-register state: empty or presenting a request to memory.
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/tag_fifo.sv
// Tag FIFO: remembers the requester of each in-flight memory request.
// Ports: clk, rst (sync, active-high); push/push_tag write a tag,
// pop retires the head; head, count, empty, full report occupancy.
module tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tag_e          push_tag,
  input  logic          pop,
  output tag_e          head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_e          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop frees the head slot in the same cycle, so push is legal when full.
  assign do_push = push & (~full | do_pop);

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (do_pop & ~do_push) count <= count - CW'(1);
    end
  end

  // Tag storage; contents are don't-care while not counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port.
// Fixed priority to data with a starvation bound for fetch; in-order
// responses are routed back using a tag FIFO.
// Ports: i_req_*/i_rsp_* fetch side, d_req_*/d_rsp_* load/store side,
// m_req_*/m_rsp_* memory side, err sticky protocol error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW           = DEF_AW,
  parameter int unsigned DW           = DEF_DW,
  parameter int unsigned MAX_OUT      = DEF_MAX_OUT,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  output logic            i_rsp_valid,
  output logic [DW-1:0]   i_rsp_data,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_req_addr,
  input  logic            d_req_we,
  input  logic [DW-1:0]   d_req_wdata,
  input  logic [DW/8-1:0] d_req_wstrb,
  output logic            d_rsp_valid,
  output logic [DW-1:0]   d_rsp_data,
  output logic            m_req_valid,
  output logic [AW-1:0]   m_req_addr,
  output logic            m_req_we,
  output logic [DW-1:0]   m_req_wdata,
  output logic [DW/8-1:0] m_req_wstrb,
  input  logic            m_req_ready,
  input  logic            m_rsp_valid,
  input  logic [DW-1:0]   m_rsp_data,
  output logic            err
);

  localparam int unsigned CW  = $clog2(MAX_OUT + 1);
  localparam int unsigned CW1 = CW + 1;
  localparam int unsigned SW  = $clog2(STARVE_LIMIT + 1);

  state_e         state;
  state_e         state_next;
  tag_e           hold_tag;
  logic [SW-1:0]  starve_cnt;
  logic           fire;
  logic           can_accept;
  logic           inst_win;
  logic           i_acc;
  logic           d_acc;
  logic [CW1-1:0] slots;
  logic           rsp_pop;
  tag_e           fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;

  assign m_req_valid = (state == ISSUE);
  assign rsp_pop     = m_rsp_valid & ~fifo_empty;

  // Next state, grant and readies; no dependence on m_rsp_valid.
  always_comb begin
    state_next  = state;
    fire        = 1'b0;
    slots       = '0;
    can_accept  = 1'b0;
    inst_win    = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    i_acc       = 1'b0;
    d_acc       = 1'b0;

    fire       = (state == ISSUE) & m_req_ready;
    slots      = CW1'(fifo_count) + CW1'(fire) + CW1'(1);
    can_accept = ~rst & ~fifo_full & ((state == IDLE) | fire) & (slots <= CW1'(MAX_OUT));
    inst_win   = ~d_req_valid | (starve_cnt == SW'(STARVE_LIMIT));

    i_req_ready = can_accept & i_req_valid & inst_win;
    d_req_ready = can_accept & d_req_valid & ~inst_win;
    i_acc       = i_req_valid & i_req_ready;
    d_acc       = d_req_valid & d_req_ready;

    if (i_acc | d_acc) state_next = ISSUE;
    else if (fire)     state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Holding register driving the memory request.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req_addr  <= '0;
      m_req_we    <= 1'b0;
      m_req_wdata <= '0;
      m_req_wstrb <= '0;
      hold_tag    <= TAG_INST;
    end else if (i_acc) begin
      m_req_addr  <= i_req_addr;
      m_req_we    <= 1'b0;
      m_req_wdata <= '0;
      m_req_wstrb <= '0;
      hold_tag    <= TAG_INST;
    end else if (d_acc) begin
      m_req_addr  <= d_req_addr;
      m_req_we    <= d_req_we;
      m_req_wdata <= d_req_wdata;
      m_req_wstrb <= d_req_wstrb;
      hold_tag    <= TAG_DATA;
    end
  end

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst)                      starve_cnt <= '0;
    else if (~i_req_valid | i_acc) starve_cnt <= '0;
    else if (d_acc)               starve_cnt <= starve_cnt + SW'(1);
  end

  tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fire),
    .push_tag (hold_tag),
    .pop      (rsp_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Response routing and sticky error on an unexpected response.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      err         <= 1'b0;
    end else begin
      i_rsp_valid <= rsp_pop & (fifo_head == TAG_INST);
      d_rsp_valid <= rsp_pop & (fifo_head == TAG_DATA);
      if (rsp_pop & (fifo_head == TAG_INST)) i_rsp_data <= m_rsp_data;
      if (rsp_pop & (fifo_head == TAG_DATA)) d_rsp_data <= m_rsp_data;
      if (m_rsp_valid & fifo_empty)          err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic
// checked against an in-order request/response queue model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int NRAND = 600;

  logic clk = 1'b0;
  logic rst;
  logic i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic d_req_we;
  logic [DW-1:0] d_req_wdata;
  logic [DW/8-1:0] d_req_wstrb;
  logic d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic m_req_valid;
  logic [AW-1:0] m_req_addr;
  logic m_req_we;
  logic [DW-1:0] m_req_wdata;
  logic [DW/8-1:0] m_req_wstrb;
  logic m_req_ready, m_rsp_valid;
  logic [DW-1:0] m_rsp_data;
  logic err;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_ready(m_req_ready),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            data;   // 0 = fetch, 1 = load/store
    logic [AW-1:0]   addr;
    logic            we;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
  } req_t;

  int tests = 0;
  int fails = 0;

  req_t acc_q[$];    // accepted, not yet issued to memory
  req_t pend_q[$];   // issued, awaiting memory response
  req_t r;
  req_t r2;
  logic exp_iv, exp_dv, exp_dload;
  logic [DW-1:0] exp_data;
  logic ia, da, rsp_send;
  int dstreak, outstanding, grants;
  logic [DW-1:0] hold_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 0; i_req_addr = '0;
    d_req_valid = 0; d_req_addr = '0; d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next();
    next();
    rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset values ----------------
    do_reset();
    #1;
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_req_addr", m_req_addr, 0);
    chk("rst_m_req_we", m_req_we, 0);
    chk("rst_m_req_wdata", m_req_wdata, 0);
    chk("rst_m_req_wstrb", m_req_wstrb, 0);
    chk("rst_i_rsp_valid", i_rsp_valid, 0);
    chk("rst_d_rsp_valid", d_rsp_valid, 0);
    chk("rst_i_rsp_data", i_rsp_data, 0);
    chk("rst_d_rsp_data", d_rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_i_req_ready", i_req_ready, 0);
    chk("rst_d_req_ready", d_req_ready, 0);

    // ---------------- single fetch ----------------
    m_req_ready = 1;
    i_req_valid = 1; i_req_addr = 32'h100;
    #1;
    chk("fetch_i_ready", i_req_ready, 1);
    chk("fetch_d_ready", d_req_ready, 0);
    next();
    i_req_valid = 0;
    #1;
    chk("fetch_m_valid", m_req_valid, 1);
    chk("fetch_m_addr", m_req_addr, 32'h100);
    chk("fetch_m_we", m_req_we, 0);
    chk("fetch_m_wstrb", m_req_wstrb, 0);
    next();
    chk("fetch_m_valid_drop", m_req_valid, 0);
    next();
    next();
    m_rsp_valid = 1; m_rsp_data = 32'hDEADBEEF;
    #1;
    chk("fetch_no_early_rsp", i_rsp_valid, 0);
    next();
    m_rsp_valid = 0;
    chk("fetch_i_rsp_valid", i_rsp_valid, 1);
    chk("fetch_i_rsp_data", i_rsp_data, 32'hDEADBEEF);
    chk("fetch_d_rsp_quiet", d_rsp_valid, 0);
    chk("fetch_err", err, 0);
    next();
    chk("fetch_i_rsp_pulse", i_rsp_valid, 0);
    chk("fetch_d_rsp_quiet2", d_rsp_valid, 0);

    // ---------------- simultaneous requests ----------------
    do_reset();
    m_req_ready = 1;
    i_req_valid = 1; i_req_addr = 32'h200;
    d_req_valid = 1; d_req_addr = 32'h8000; d_req_we = 0;
    #1;
    chk("simul_d_ready", d_req_ready, 1);
    chk("simul_i_ready", i_req_ready, 0);
    next();
    d_req_valid = 0;
    #1;
    chk("simul_first_addr", m_req_addr, 32'h8000);
    chk("simul_i_ready2", i_req_ready, 1);
    next();
    i_req_valid = 0;
    #1;
    chk("simul_second_addr", m_req_addr, 32'h200);
    chk("simul_second_valid", m_req_valid, 1);
    next();
    m_rsp_valid = 1; m_rsp_data = 32'h11;
    next();
    m_rsp_data = 32'h22;
    chk("simul_d_rsp_valid", d_rsp_valid, 1);
    chk("simul_d_rsp_data", d_rsp_data, 32'h11);
    chk("simul_i_rsp_quiet", i_rsp_valid, 0);
    next();
    m_rsp_valid = 0;
    chk("simul_i_rsp_valid", i_rsp_valid, 1);
    chk("simul_i_rsp_data", i_rsp_data, 32'h22);
    chk("simul_d_rsp_quiet", d_rsp_valid, 0);
    chk("simul_err", err, 0);

    // ---------------- starvation ----------------
    do_reset();
    m_req_ready = 1;
    i_req_valid = 1; i_req_addr = 32'h1000;
    d_req_valid = 1; d_req_addr = 32'h2000;
    outstanding = 0;
    grants = 0;
    for (int c = 0; c < 80 && grants < 15; c++) begin
      m_rsp_valid = (outstanding > 0);
      m_rsp_data = 32'(c);
      #1;
      if (i_req_ready || d_req_ready) begin
        chk("starve_grant", {63'd0, i_req_ready}, ((grants % 5) == 4) ? 64'd1 : 64'd0);
        grants++;
      end
      if (m_rsp_valid) outstanding--;
      if (m_req_valid && m_req_ready) outstanding++;
      next();
    end
    chk("starve_grant_count", grants, 15);
    chk("starve_err", err, 0);

    // ---------------- backpressure and outstanding limit ----------------
    do_reset();
    d_req_valid = 1; d_req_addr = 32'h40;
    #1;
    chk("bp_first_d_ready", d_req_ready, 1);
    next();
    d_req_addr = 32'h500;
    i_req_valid = 1; i_req_addr = 32'h300;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_m_valid", m_req_valid, 1);
      chk("bp_m_addr", m_req_addr, 32'h40);
      chk("bp_i_ready", i_req_ready, 0);
      chk("bp_d_ready", d_req_ready, 0);
      next();
    end
    m_req_ready = 1;
    #1;
    chk("bp_release_d_ready", d_req_ready, 1);
    next();
    d_req_valid = 0;
    #1;
    chk("bp_m_addr2", m_req_addr, 32'h500);
    chk("bp_full_i_ready", i_req_ready, 0);
    next();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_limit_i_ready", i_req_ready, 0);
      next();
    end
    m_rsp_valid = 1; m_rsp_data = 32'h77;
    #1;
    chk("bp_rsp_cycle_i_ready", i_req_ready, 0);
    next();
    m_rsp_valid = 0;
    #1;
    chk("bp_after_rsp_i_ready", i_req_ready, 1);
    chk("bp_first_rsp_data", d_rsp_data, 32'h77);
    next();
    i_req_valid = 0;

    // ---------------- store acknowledge ----------------
    do_reset();
    m_req_ready = 1;
    d_req_valid = 1; d_req_addr = 32'h44; d_req_we = 1;
    d_req_wdata = 32'hCAFEF00D; d_req_wstrb = 4'h3;
    next();
    d_req_valid = 0; d_req_we = 0;
    #1;
    chk("st_m_we", m_req_we, 1);
    chk("st_m_wstrb", m_req_wstrb, 4'h3);
    chk("st_m_wdata", m_req_wdata, 32'hCAFEF00D);
    chk("st_m_addr", m_req_addr, 32'h44);
    next();
    m_rsp_valid = 1; m_rsp_data = 32'h0;
    next();
    m_rsp_valid = 0;
    chk("st_ack", d_rsp_valid, 1);
    chk("st_no_i_rsp", i_rsp_valid, 0);
    next();
    chk("st_ack_pulse", d_rsp_valid, 0);

    // ---------------- errors and reset ----------------
    do_reset();
    m_rsp_valid = 1; m_rsp_data = 32'h55;
    next();
    m_rsp_valid = 0;
    chk("err_set", err, 1);
    chk("err_no_i_rsp", i_rsp_valid, 0);
    chk("err_no_d_rsp", d_rsp_valid, 0);
    next();
    next();
    chk("err_sticky", err, 1);
    do_reset();
    #1;
    chk("err_cleared", err, 0);
    m_req_ready = 1;
    i_req_valid = 1; i_req_addr = 32'hA0;
    next();
    i_req_valid = 0;
    d_req_valid = 1; d_req_addr = 32'hB0; d_req_we = 1; d_req_wdata = 32'h1234; d_req_wstrb = 4'hF;
    #1;
    chk("rstis_d_ready", d_req_ready, 1);
    next();
    d_req_valid = 0; m_req_ready = 0;
    #1;
    chk("rstis_issue", m_req_valid, 1);
    rst = 1;
    next();
    rst = 0;
    #1;
    chk("rstis_m_valid", m_req_valid, 0);
    chk("rstis_m_addr", m_req_addr, 0);
    chk("rstis_m_we", m_req_we, 0);
    chk("rstis_m_wdata", m_req_wdata, 0);
    chk("rstis_m_wstrb", m_req_wstrb, 0);
    chk("rstis_err", err, 0);
    chk("rstis_rsp", {62'd0, i_rsp_valid, d_rsp_valid}, 0);
    m_rsp_valid = 1;
    next();
    m_rsp_valid = 0;
    chk("rstis_fifo_empty_err", err, 1);
    chk("rstis_no_rsp", {62'd0, i_rsp_valid, d_rsp_valid}, 0);

    // ---------------- randomized traffic ----------------
    do_reset();
    exp_iv = 0; exp_dv = 0; exp_dload = 0; exp_data = '0;
    dstreak = 0;
    acc_q.delete();
    pend_q.delete();
    for (int c = 0; c < NRAND + 300; c++) begin
      chk("rnd_i_rsp_valid", i_rsp_valid, exp_iv);
      if (exp_iv) chk("rnd_i_rsp_data", i_rsp_data, exp_data);
      chk("rnd_d_rsp_valid", d_rsp_valid, exp_dv);
      if (exp_dv && exp_dload) chk("rnd_d_rsp_data", d_rsp_data, exp_data);
      chk("rnd_err", err, 0);
      if (c >= NRAND && acc_q.size() == 0 && pend_q.size() == 0 && !m_req_valid) break;

      if (c < NRAND && !i_req_valid && $urandom_range(0, 1) == 1) begin
        i_req_valid = 1;
        i_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (c < NRAND && !d_req_valid && $urandom_range(0, 1) == 1) begin
        d_req_valid = 1;
        d_req_addr = $urandom;
        d_req_we = 1'($urandom_range(0, 1));
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom_range(0, 15));
      end
      m_req_ready = (c >= NRAND) || ($urandom_range(0, 3) != 0);
      rsp_send = (pend_q.size() > 0) && ((c >= NRAND) || ($urandom_range(0, 2) == 0));
      m_rsp_valid = rsp_send;
      m_rsp_data = $urandom;
      #1;

      chk("rnd_one_ready", {63'd0, i_req_ready & d_req_ready}, 0);
      chk("rnd_inflight_le_max", (pend_q.size() + int'(m_req_valid)) <= MAX_OUT, 1);
      if (i_req_valid && d_req_valid && i_req_ready)
        chk("rnd_fetch_only_when_starved", dstreak, STARVE_LIMIT);
      ia = i_req_valid & i_req_ready;
      da = d_req_valid & d_req_ready;

      // Memory returns the oldest issued request first.
      exp_iv = 0; exp_dv = 0;
      if (rsp_send) begin
        r2 = pend_q.pop_front();
        exp_iv = !r2.data;
        exp_dv = r2.data;
        exp_dload = !r2.we;
        exp_data = m_rsp_data;
      end
      if (m_req_valid && m_req_ready) begin
        chk("rnd_fire_has_req", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) begin
          r = acc_q.pop_front();
          chk("rnd_m_addr", m_req_addr, r.addr);
          chk("rnd_m_we", m_req_we, r.we);
          chk("rnd_m_wstrb", m_req_wstrb, r.wstrb);
          if (r.we) chk("rnd_m_wdata", m_req_wdata, r.wdata);
          pend_q.push_back(r);
        end
      end
      if (ia) begin
        r.data = 0; r.addr = i_req_addr; r.we = 0; r.wdata = '0; r.wstrb = '0;
        acc_q.push_back(r);
      end
      if (da) begin
        r.data = 1; r.addr = d_req_addr; r.we = d_req_we; r.wdata = d_req_wdata; r.wstrb = d_req_wstrb;
        acc_q.push_back(r);
      end
      if (!i_req_valid || ia) dstreak = 0;
      else if (da) dstreak++;
      chk("rnd_streak_bound", dstreak <= STARVE_LIMIT, 1);

      next();
      if (ia) i_req_valid = 0;
      if (da) d_req_valid = 0;
    end
    chk("rnd_drained", acc_q.size() + pend_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
